tinyalu_responder: RTL and testbench
====================================

# tinyalu_responder

Sequential ALU sitting on the responder side of the team's start/done command protocol: accepts a latched command (op, A, B) when start is raised, executes it, and returns result with a one-cycle done pulse. Logic ops and add complete in one execute cycle; multiply uses an iterative shift-add datapath taking WIDTH cycles. This is the DUT-side counterpart to the team's stimulus drivers. It is intended as a drop-in multi-cycle ALU core behind that protocol.

## Interface
- WIDTH, 8, operand width; result is 2*WIDTH bits; multiply takes WIDTH iteration cycles
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  command request, level; requester holds it with op/A/B stable until done seen
- op  input  3  0 no_op, 1 add_op, 2 and_op, 3 xor_op, 4 mul_op, 7 rst_op; 5 and 6 behave as no_op
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- done  output  1  one-cycle completion pulse
- busy  output  1  high from command capture until the done cycle inclusive
- result  output  2*WIDTH  result of last completed command, held until next completion

## Operation
- States: IDLE, EXEC, MUL, HOLD.
- IDLE: on edge with start=1, latch op/A/B. If op=mul_op go to MUL (load multiplicand=A, multiplier=B, acc=0, count=0); otherwise go to EXEC.
- EXEC: one edge; write result, assert done, go to HOLD.
  - add: {WIDTH-1 zeros, A+B carry-extended} (WIDTH+1-bit sum, zero-extended)
  - and / xor: bitwise, zero-extended
  - rst_op: result <= 0
  - no_op, 5, 6: result unchanged; done still pulses
- MUL: each edge, if multiplier LSB=1 acc += multiplicand<<count; shift multiplier right; count++. On the WIDTH-th step, result <= final acc, done=1, go to HOLD. Product exact (unsigned, 2*WIDTH bits, no overflow).
- HOLD: done=0 after its single cycle. Remain while start=1; go to IDLE on first edge with start=0. One command per start assertion; holding start after done never triggers a second command.
- start dropped during EXEC/MUL: ignored; command completes with its latched operands, done pulses, HOLD exits on the next edge.
- op/A/B changes after capture are ignored.
- Reset (any time, including mid-MUL): state=IDLE, done=0, busy=0, result=0, acc/count=0; in-flight command discarded, no done issued.

## Timing
- Reset values: done=0, busy=0, result=0.
- Capture edge k (IDLE, start=1): busy=1 after edge k.
- Single-cycle ops: result and done valid after edge k+1; done low after edge k+2; busy low after edge k+2.
- mul_op: result and done valid after edge k+WIDTH (k+8 at default); done low after edge k+WIDTH+1.
- Earliest next capture: first edge in IDLE, i.e. at least one edge with start=0 sampled in HOLD, so minimum command-to-command spacing is 3 cycles (single-cycle op) / WIDTH+2 cycles (mul).
- result changes only on the done cycle or on reset.

## Test plan
- Reset 2 cycles, then A=3, B=5, op=mul_op, start=1 -> done single pulse 8 cycles after capture, result=15; start held through done -> no second pulse.
- A=255, B=255, op=add_op -> done 1 cycle after capture, result=510; then op=mul_op same operands -> result=65025.
- A=0xF0, B=0x3C: and_op -> result=0x0030; xor_op -> result=0x00CC; then op=5 -> done pulses, result stays 0x00CC.
- result=0x00CC, op=rst_op -> done pulse, result=0x0000.
- mul_op A=200, B=100, assert reset 4 cycles after capture -> done never pulses, result=0, busy=0; next mul 2*7 after release -> result=14.
- mul_op A=9, B=9, drop start 2 cycles after capture -> done still after edge k+8 with result=81; new command accepted on next start rise.

Source files
------------

// File: rtl/tinyalu_responder_if.sv
// rtl/tinyalu_responder_if.sv - start/done command bus between requester and ALU responder
// The requester (master) holds start with op/A/B stable until it sees done.
interface tinyalu_responder_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [2:0]           op;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 done;
   logic                 busy;
   logic [2*WIDTH-1:0]   result;

   modport master (
      output start, op, A, B,
      input  done, busy, result
   );

   modport slave (
      input  start, op, A, B,
      output done, busy, result
   );
endinterface

// File: rtl/tinyalu_responder.sv
// rtl/tinyalu_responder.sv - multi-cycle ALU responder for the start/done command protocol
// Logic ops and add take one execute cycle; multiply is WIDTH shift-add steps.
module tinyalu_responder #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   tinyalu_responder_if.slave   bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_MUL  = 2'd2;
   localparam logic [1:0] S_HOLD = 2'd3;

   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;
   localparam logic [2:0] OP_RST = 3'd7;

   logic [1:0]           r_state;
   logic [2:0]           r_op;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;
   logic [CW-1:0]        r_count;
   logic [2*WIDTH-1:0]   r_result;
   logic                 r_done;

   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_exec_result;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic                 w_last_step;

   assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
   // The multiplicand is shifted left each step, so it is always aligned with multiplier bit 0.
   assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_last_step = (r_count == CW'(WIDTH - 1));

   always_comb begin
      w_exec_result = r_result;
      case (r_op)
         OP_ADD:  w_exec_result = {{(WIDTH-1){1'b0}}, w_sum};
         OP_AND:  w_exec_result = {{WIDTH{1'b0}}, r_a & r_b};
         OP_XOR:  w_exec_result = {{WIDTH{1'b0}}, r_a ^ r_b};
         OP_RST:  w_exec_result = '0;
         default: w_exec_result = r_result;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_op <= bus.op;
                  r_a  <= bus.A;
                  r_b  <= bus.B;
                  if (bus.op == OP_MUL) begin
                     r_mcand  <= {{WIDTH{1'b0}}, bus.A};
                     r_mplier <= bus.B;
                     r_acc    <= '0;
                     r_count  <= '0;
                     r_state  <= S_MUL;
                  end else begin
                     r_state  <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               r_result <= w_exec_result;
               r_done   <= 1'b1;
               r_state  <= S_HOLD;
            end
            S_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + 1'b1;
               if (w_last_step) begin
                  r_result <= w_acc_next;
                  r_done   <= 1'b1;
                  r_state  <= S_HOLD;
               end
            end
            default: begin
               // Wait for start to fall so one assertion yields exactly one command.
               if (!bus.start) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.done   = r_done;
   assign bus.busy   = (r_state == S_EXEC) || (r_state == S_MUL) || r_done;
   assign bus.result = r_result;
endmodule

// File: tb/tb_tinyalu_responder.sv
// tb/tb_tinyalu_responder.sv - scoreboard bench for tinyalu_responder
// Stimulus pushes expected result and done cycle; a negedge monitor pops and compares on done.
module tb_tinyalu_responder;
   localparam int W = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   tinyalu_responder_if #(.WIDTH(W)) bus ();

   tinyalu_responder #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2*W-1:0] res;
      int             at;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'(bus.done), 32'd0);
         end else begin : pop_one
            exp_t e;
            e = sb.pop_front();
            chk("result", 32'(bus.result), 32'(e.res));
            chk("done_cycle", 32'(cyc), 32'(e.at));
            chk("busy_on_done", 32'(bus.busy), 32'd1);
         end
      end
   end

   task automatic do_cmd(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp, input int lat, input int hold, input int drop_at);
      int k;
      bit seen;
      bus.start = 1'b1;
      bus.op    = o;
      bus.A     = a;
      bus.B     = b;
      @(posedge clk);
      #1;
      k = cyc;
      sb.push_back('{exp, k + lat});
      chk("busy_capture", 32'(bus.busy), 32'd1);
      bus.A  = ~a;
      bus.B  = a ^ 8'h5A;
      bus.op = (o == 3'd7) ? 3'd4 : 3'd7;
      seen = 1'b0;
      for (int i = 1; i <= W + 4 && !seen; i++) begin
         @(negedge clk);
         if (i == drop_at) bus.start = 1'b0;
         if (bus.done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
      if (!seen) sb.delete();
      @(negedge clk);
      chk("done_low", 32'(bus.done), 32'd0);
      chk("busy_low", 32'(bus.busy), 32'd0);
      repeat (hold) @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0;
      bus.op    = 3'd0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (2) @(negedge clk);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_result", 32'(bus.result), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      do_cmd(3'd4, 8'd3,   8'd5,   16'd15,    8, 5, 0);
      do_cmd(3'd1, 8'd255, 8'd255, 16'd510,   1, 0, 0);
      do_cmd(3'd4, 8'd255, 8'd255, 16'd65025, 8, 0, 0);
      do_cmd(3'd2, 8'hF0,  8'h3C,  16'h0030,  1, 0, 0);
      do_cmd(3'd3, 8'hF0,  8'h3C,  16'h00CC,  1, 0, 0);
      do_cmd(3'd5, 8'h12,  8'h34,  16'h00CC,  1, 0, 0);
      do_cmd(3'd7, 8'hAA,  8'h55,  16'h0000,  1, 0, 0);
      do_cmd(3'd4, 8'd9,   8'd9,   16'd81,    8, 0, 2);

      bus.start = 1'b1;
      bus.op    = 3'd4;
      bus.A     = 8'd200;
      bus.B     = 8'd100;
      @(posedge clk);
      #1;
      chk("busy_mul_abort", 32'(bus.busy), 32'd1);
      repeat (4) @(negedge clk);
      reset     = 1'b1;
      bus.start = 1'b0;
      #1;
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_result", 32'(bus.result), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("idle_after_abort", 32'(bus.busy), 32'd0);

      do_cmd(3'd4, 8'd2, 8'd7, 16'd14, 8, 0, 0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
